// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment encodings and display geometry
package seg_pkg;
    localparam int DIGITS = 4;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [15:0][6:0] SEG_TABLE = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                              SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low {g..a} segment decoder
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed 4-digit hex display driver with double-buffered value
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       value_in,
    input  logic              value_valid,
    input  logic [DIGITS-1:0] dp_in,
    input  logic              blank_lz,
    output logic [DIGITS-1:0] anode_n,
    output logic [6:0]        cathode_n,
    output logic              dp_n,
    output logic              digit_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    logic [CW-1:0]     presc;
    logic [1:0]        idx, idx_nxt;
    logic              tick, frame_load, blank;
    logic [15:0]       shadow_val, active_val, active_nxt;
    logic [DIGITS-1:0] shadow_dp, active_dp, active_dp_nxt, zero_from;
    logic [6:0]        seg;

    assign tick          = presc == CW'(REFRESH_DIV - 1);
    assign idx_nxt       = idx + 2'd1;
    assign frame_load    = tick && idx_nxt == 2'd0;
    // a strobe landing on the frame-load edge bypasses the shadow so it is not a frame late
    assign active_nxt    = !frame_load ? active_val : value_valid ? value_in : shadow_val;
    assign active_dp_nxt = !frame_load ? active_dp : value_valid ? dp_in : shadow_dp;
    assign zero_from[3]  = active_nxt[15:12] == 4'd0;
    assign zero_from[2]  = zero_from[3] && active_nxt[11:8] == 4'd0;
    assign zero_from[1]  = zero_from[2] && active_nxt[7:4] == 4'd0;
    assign zero_from[0]  = 1'b0;
    assign blank         = blank_lz && zero_from[idx_nxt];

    hex_to_seg u_dec (
        .hex(active_nxt[{idx_nxt, 2'b00} +: 4]),
        .seg(seg)
    );

    // prescaler wraps at terminal count, which is the digit-advance tick
    always_ff @(posedge clk) begin
        if (rst) presc <= '0;
        else presc <= tick ? '0 : presc + 1'b1;
    end

    // digit index starts at 3 so the first tick lands on digit 0
    always_ff @(posedge clk) begin
        if (rst) idx <= 2'd3;
        else if (tick) idx <= idx_nxt;
    end

    // shadow holds the latest strobed value until the next frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (value_valid) begin
            shadow_val <= value_in;
            shadow_dp  <= dp_in;
        end
    end

    // active copy only changes at a frame boundary, so a frame is never torn
    always_ff @(posedge clk) begin
        if (rst) begin
            active_val <= '0;
            active_dp  <= '0;
        end else begin
            active_val <= active_nxt;
            active_dp  <= active_dp_nxt;
        end
    end

    // registered display outputs refreshed once per digit slot
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_n    <= '1;
            cathode_n  <= SEG_BLANK;
            dp_n       <= 1'b1;
            digit_tick <= 1'b0;
        end else begin
            digit_tick <= tick;
            if (tick) begin
                anode_n   <= ~(DIGITS'(1) << idx_nxt);
                cathode_n <= blank ? SEG_BLANK : seg;
                dp_n      <= blank | ~active_dp_nxt[idx_nxt];
            end
        end
    end
endmodule
